// File: rtl/demux_tdm_1_4_if.sv
// Bus bundle for the 1:4 TDM demultiplexer: serial word stream in, four parallel channel words out.
// The master drives the stream and the slave (the demultiplexer) produces the decoded frame.
interface demux_tdm_1_4_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] D;
    logic             valid;
    logic             sync;
    logic [WIDTH-1:0] Y0;
    logic [WIDTH-1:0] Y1;
    logic [WIDTH-1:0] Y2;
    logic [WIDTH-1:0] Y3;
    logic [1:0]       S;
    logic             frame_valid;
    logic             err;

    modport master (
        output D, valid, sync,
        input  Y0, Y1, Y2, Y3, S, frame_valid, err
    );

    modport slave (
        input  D, valid, sync,
        output Y0, Y1, Y2, Y3, S, frame_valid, err
    );
endinterface

// File: rtl/demux_tdm_1_4.sv
// 1:4 time-division demultiplexer. A sync-marked word opens a frame, and the three words after it
// complete the frame. The four channel outputs update together, one cycle after the last word arrives.
module demux_tdm_1_4 #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demux_tdm_1_4_if.slave        bus
);

    typedef enum logic {
        HUNT,
        COLLECT
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [1:0]       r_slot;
    logic [1:0]       w_slotNext;
    logic [WIDTH-1:0] r_shadow [0:3];
    logic [WIDTH-1:0] w_shadowNext [0:3];
    logic [WIDTH-1:0] r_y [0:3];
    logic [WIDTH-1:0] w_yNext [0:3];
    logic             r_frameValid;
    logic             w_frameValidNext;
    logic             r_err;
    logic             w_errNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= HUNT;
            r_slot       <= 2'd0;
            r_shadow     <= '{default: '0};
            r_y          <= '{default: '0};
            r_frameValid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_slot       <= w_slotNext;
            r_shadow     <= w_shadowNext;
            r_y          <= w_yNext;
            r_frameValid <= w_frameValidNext;
            r_err        <= w_errNext;
        end
    end

    // The slot-3 word goes straight from D to Y3, so the frame completes on the same edge that samples that word.
    always_comb begin
        w_stateNext      = r_state;
        w_slotNext       = r_slot;
        w_shadowNext     = r_shadow;
        w_yNext          = r_y;
        w_frameValidNext = 1'b0;
        w_errNext        = 1'b0;

        if (bus.valid) begin
            case (r_state)
                HUNT: begin
                    if (bus.sync) begin
                        w_shadowNext[0] = bus.D;
                        w_slotNext      = 2'd1;
                        w_stateNext     = COLLECT;
                    end
                end
                COLLECT: begin
                    if (bus.sync) begin
                        w_errNext       = 1'b1;
                        w_shadowNext[0] = bus.D;
                        w_slotNext      = 2'd1;
                    end else if (r_slot == 2'd3) begin
                        w_shadowNext[3]  = bus.D;
                        w_yNext[0]       = r_shadow[0];
                        w_yNext[1]       = r_shadow[1];
                        w_yNext[2]       = r_shadow[2];
                        w_yNext[3]       = bus.D;
                        w_frameValidNext = 1'b1;
                        w_slotNext       = 2'd0;
                        w_stateNext      = HUNT;
                    end else begin
                        w_shadowNext[r_slot] = bus.D;
                        w_slotNext           = r_slot + 2'd1;
                    end
                end
                default: begin
                    w_stateNext = HUNT;
                    w_slotNext  = 2'd0;
                end
            endcase
        end
    end

    assign bus.Y0          = r_y[0];
    assign bus.Y1          = r_y[1];
    assign bus.Y2          = r_y[2];
    assign bus.Y3          = r_y[3];
    assign bus.S           = r_slot;
    assign bus.frame_valid = r_frameValid;
    assign bus.err         = r_err;

endmodule

// File: tb/tb_demux_tdm_1_4.sv
// Testbench for demux_tdm_1_4. A behavioural protocol model predicts S, err and frame_valid each cycle,
// and completed frames are queued and matched against the outputs when frame_valid pulses.
module tb_demux_tdm_1_4;

    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst_n;

    demux_tdm_1_4_if #(.WIDTH(WIDTH)) bus ();

    demux_tdm_1_4 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [4*WIDTH-1:0] sb [$];
    logic [4*WIDTH-1:0] mY;
    logic [WIDTH-1:0]   mShadow [0:3];
    int                 mS;
    logic               mHunt;
    logic               expFv;
    logic               expErr;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mS     = 0;
        mHunt  = 1'b1;
        mY     = '0;
        expFv  = 1'b0;
        expErr = 1'b0;
        for (int i = 0; i < 4; i++) mShadow[i] = '0;
    endtask

    task automatic checkCycle();
        checkOutput("S", 32'(bus.S), 32'(mS));
        checkOutput("err", 32'(bus.err), 32'(expErr));
        checkOutput("frame_valid", 32'(bus.frame_valid), 32'(expFv));
        if (bus.frame_valid) begin
            checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) mY = sb.pop_front();
        end
        checkOutput("Y", 32'({bus.Y3, bus.Y2, bus.Y1, bus.Y0}), 32'(mY));
    endtask

    // Drive one cycle of input starting at a negedge, advance the model, then check at the next negedge.
    task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic v, input logic s);
        bus.D     = d;
        bus.valid = v;
        bus.sync  = s;
        expFv     = 1'b0;
        expErr    = 1'b0;
        if (v) begin
            if (mHunt) begin
                if (s) begin
                    mShadow[0] = d;
                    mS         = 1;
                    mHunt      = 1'b0;
                end
            end else if (s) begin
                expErr     = 1'b1;
                mShadow[0] = d;
                mS         = 1;
            end else if (mS == 3) begin
                sb.push_back({d, mShadow[2], mShadow[1], mShadow[0]});
                expFv = 1'b1;
                mS    = 0;
                mHunt = 1'b1;
            end else begin
                mShadow[mS] = d;
                mS++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        checkCycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, 1'b0);
    endtask

    task automatic sendFrame(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] e);
        applyStimulus(a, 1'b1, 1'b1);
        applyStimulus(b, 1'b1, 1'b0);
        applyStimulus(c, 1'b1, 1'b0);
        applyStimulus(e, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.D     = '0;
        bus.valid = 1'b0;
        bus.sync  = 1'b0;
        modelReset();
        #12;
        checkCycle();
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame with valid on every cycle
        sendFrame(4'd4, 4'd8, 4'd1, 4'd15);
        idle(2);

        // Words arriving while hunting are dropped, including a sync that arrives without valid
        applyStimulus(4'd7, 1'b1, 1'b0);
        applyStimulus(4'd9, 1'b1, 1'b0);
        applyStimulus(4'd5, 1'b0, 1'b1);
        sendFrame(4'd2, 4'd3, 4'd5, 4'd6);
        idle(1);

        // A premature sync aborts the partial frame and restarts at slot 0
        sendFrame(4'd4, 4'd8, 4'd1, 4'd15);
        applyStimulus(4'd10, 1'b1, 1'b1);
        applyStimulus(4'd11, 1'b1, 1'b0);
        applyStimulus(4'd12, 1'b1, 1'b1);
        applyStimulus(4'd13, 1'b1, 1'b0);
        applyStimulus(4'd14, 1'b1, 1'b0);
        applyStimulus(4'd0, 1'b1, 1'b0);
        idle(1);

        // Gaps between slots, including a sync that arrives without valid mid-frame
        applyStimulus(4'd1, 1'b1, 1'b1);
        applyStimulus(4'd2, 1'b1, 1'b0);
        idle(2);
        applyStimulus(4'd9, 1'b0, 1'b1);
        applyStimulus(4'd3, 1'b1, 1'b0);
        idle(1);
        applyStimulus(4'd4, 1'b1, 1'b0);
        idle(2);

        // Back-to-back frames
        sendFrame(4'd4, 4'd8, 4'd1, 4'd15);
        sendFrame(4'd15, 4'd1, 4'd8, 4'd4);
        idle(1);

        // Asynchronous reset between clock edges, mid-frame
        applyStimulus(4'd6, 1'b1, 1'b1);
        applyStimulus(4'd7, 1'b1, 1'b0);
        bus.valid = 1'b0;
        bus.sync  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkCycle();
        @(negedge clk);
        rst_n = 1'b1;
        checkCycle();
        sendFrame(4'd4, 4'd8, 4'd1, 4'd15);
        idle(1);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            applyStimulus(WIDTH'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 5) == 0));
        end
        idle(2);

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
